prism_cfg_loader: RTL and testbench

Sequencer that brings up the PRISM controller from a software-pushed configuration image. Host words are buffered in a small FIFO. The block holds PRISM in debug reset, streams the words onto sequential debug addresses, then releases reset and enables the FSM. It sits between the TinyQV register interface and the PRISM debug port, and arbitrates that port between direct host writes and its own loader writes.

---
 rtl/prism_cfg_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_prism_cfg_loader.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prism_cfg_loader.sv
// prism_cfg_loader
//   Brings up the PRISM controller from a software-pushed configuration
//   image. Host words are buffered in a FIFO. The sequencer holds PRISM in
//   debug reset, streams the words to consecutive debug addresses, then
//   releases reset and enables the PRISM FSM. The PRISM debug port is shared
//   between direct host writes, which always win, and loader writes.
//
//   Build option: define PRISM_LOADER_VERIFY_EN to read back every loaded
//   word (CHECK state) and to flag mismatches (FAULT state, sticky error).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          single-cycle control pulses
//   start_addr, word_count  first debug address and word count (latched on start)
//   wr_valid/wr_data/wr_ready  host push into the configuration FIFO
//   host_wr/host_addr/host_wdata  direct host debug write (priority)
//   dbg_rdata             PRISM debug read data (combinational on dbg_addr)
//   dbg_addr/dbg_wr/dbg_wdata  PRISM debug write port
//   dbg_reset, fsm_enable PRISM debug reset and FSM enable
//   busy, done, error     status: busy in RESET/LOAD/CHECK, done pulse on
//                         entry to RUN, sticky readback mismatch
module prism_cfg_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [5:0]  start_addr,
  input  logic [5:0]  word_count,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic        host_wr,
  input  logic [5:0]  host_addr,
  input  logic [31:0] host_wdata,
  input  logic [31:0] dbg_rdata,
  output logic [5:0]  dbg_addr,
  output logic        dbg_wr,
  output logic [31:0] dbg_wdata,
  output logic        dbg_reset,
  output logic        fsm_enable,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

`ifdef PRISM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_LOAD, S_CHECK, S_RUN, S_FAULT} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_RESET, S_LOAD, S_RUN} state_e;
`endif

  state_e state_q, state_d;

  // ---------------------------------------------------------------- FIFO
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          empty, full, push, pop;
  logic [31:0]   head;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign wr_ready = !full;
  assign push     = wr_valid && !full && !abort;
  assign head     = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (abort) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ------------------------------------------------------- sequencer data
  logic [RCW-1:0] rcnt_q;
  logic [5:0]     idx_q, sa_q, wc_q;
  logic           start_ok, ld_fire, last, in_check;
  logic [5:0]     ld_addr;

  // Loader write fires only when the host is not using the port this cycle;
  // otherwise it simply retries next cycle with no state change.
  assign ld_fire  = (state_q == S_LOAD) && !empty && !host_wr && !abort;
  assign pop      = ld_fire;
  assign last     = (idx_q == wc_q - 6'd1);
  assign ld_addr  = sa_q + idx_q;

`ifdef PRISM_LOADER_VERIFY_EN
  logic [31:0] chk_data_q;
  logic        error_q;
  logic        chk_fire, mismatch;

  assign in_check = (state_q == S_CHECK);
  assign chk_fire = in_check && !host_wr && !abort;
  assign mismatch = (dbg_rdata != chk_data_q);
  assign start_ok = start && !abort &&
                    (state_q == S_IDLE || state_q == S_RUN || state_q == S_FAULT);
  assign error    = error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_data_q <= '0;
      error_q    <= 1'b0;
    end else begin
      if (ld_fire) chk_data_q <= head;
      if (start_ok)                  error_q <= 1'b0;
      else if (chk_fire && mismatch) error_q <= 1'b1;
    end
  end
`else
  logic unused_rdata;

  assign in_check     = 1'b0;
  assign start_ok     = start && !abort && (state_q == S_IDLE || state_q == S_RUN);
  assign error        = 1'b0;
  assign unused_rdata = ^dbg_rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt_q <= '0;
      idx_q  <= '0;
      sa_q   <= '0;
      wc_q   <= '0;
    end else begin
      rcnt_q <= (state_q == S_RESET) ? rcnt_q + 1'b1 : '0;
      if (start_ok) begin
        sa_q <= start_addr;
        wc_q <= word_count;
      end
      if (abort || start_ok) begin
        idx_q <= '0;
`ifdef PRISM_LOADER_VERIFY_EN
      end else if (chk_fire && !mismatch) begin
`else
      end else if (ld_fire) begin
`endif
        idx_q <= idx_q + 6'd1;
      end
    end
  end

  // ------------------------------------------------------- state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ----------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_RUN: if (start_ok) state_d = S_RESET;
        S_RESET: begin
          if (rcnt_q == RCW'(RST_CYCLES - 1))
            state_d = (wc_q != 6'd0) ? S_LOAD : S_RUN;
        end
        S_LOAD: begin
`ifdef PRISM_LOADER_VERIFY_EN
          if (ld_fire) state_d = S_CHECK;
`else
          if (ld_fire && last) state_d = S_RUN;
`endif
        end
`ifdef PRISM_LOADER_VERIFY_EN
        S_CHECK: begin
          if (chk_fire) begin
            if (mismatch)  state_d = S_FAULT;
            else if (last) state_d = S_RUN;
            else           state_d = S_LOAD;
          end
        end
        S_FAULT: if (start_ok) state_d = S_RESET;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------- outputs
  // Status outputs are registered from the next state so they line up with
  // the state they describe.
  logic dbg_reset_q, dbg_reset_d;
  logic fsm_enable_q, fsm_enable_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_comb begin
    dbg_reset_d  = (state_d != S_IDLE) && (state_d != S_RUN);
    fsm_enable_d = (state_d == S_RUN);
    done_d       = (state_d == S_RUN) && (state_q != S_RUN);
    busy_d       = (state_d == S_RESET) || (state_d == S_LOAD);
`ifdef PRISM_LOADER_VERIFY_EN
    busy_d       = busy_d || (state_d == S_CHECK);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_reset_q  <= 1'b0;
      fsm_enable_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      dbg_reset_q  <= dbg_reset_d;
      fsm_enable_q <= fsm_enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dbg_reset  = dbg_reset_q;
  assign fsm_enable = fsm_enable_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // Debug port mux: host path has priority every cycle.
  always_comb begin
    if (host_wr) begin
      dbg_wr    = 1'b1;
      dbg_addr  = host_addr;
      dbg_wdata = host_wdata;
    end else begin
      dbg_wr    = ld_fire;
      dbg_addr  = ((state_q == S_LOAD) || in_check) ? ld_addr : '0;
      dbg_wdata = ld_fire ? head : '0;
    end
  end

endmodule

// File: tb/tb_prism_cfg_loader.sv
module tb_prism_cfg_loader;

`ifdef PRISM_LOADER_VERIFY_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [5:0]  start_addr, word_count;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        host_wr;
  logic [5:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] dbg_rdata;
  logic [5:0]  dbg_addr;
  logic        dbg_wr;
  logic [31:0] dbg_wdata;
  logic        dbg_reset, fsm_enable, busy, done, error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int          c;
    logic [5:0]  a;
    logic [31:0] d;
  } wr_t;
  wr_t wlog[$];

  logic [31:0] tbmem [64];
  logic        corrupt = 1'b0;
  logic [5:0]  corrupt_addr = 6'h00;

  prism_cfg_loader #(.FIFO_DEPTH(4), .RST_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .start_addr(start_addr), .word_count(word_count),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .dbg_rdata(dbg_rdata), .dbg_addr(dbg_addr), .dbg_wr(dbg_wr),
    .dbg_wdata(dbg_wdata), .dbg_reset(dbg_reset), .fsm_enable(fsm_enable),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // PRISM debug memory model; a selected address can be made to read back wrong.
  always_comb dbg_rdata = tbmem[dbg_addr] ^ ((corrupt && dbg_addr == corrupt_addr) ? 32'h1 : 32'h0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n === 1'b1 && dbg_wr === 1'b1) begin
      wlog.push_back('{cyc, dbg_addr, dbg_wdata});
      tbmem[dbg_addr] <= dbg_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] sa, input logic [5:0] wc, output int t);
    start_addr = sa;
    word_count = wc;
    start      = 1'b1;
    t          = cyc;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(output int c, output bit seen);
    seen = 1'b0;
    c    = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        c    = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1)   begin errors++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    checks++; if (dbg_wr !== 1'b0)     begin errors++; $display("FAIL reset_dbg_wr: got %b want 0", dbg_wr); end
    checks++; if (dbg_reset !== 1'b0)  begin errors++; $display("FAIL reset_dbg_reset: got %b want 0", dbg_reset); end
    checks++; if (fsm_enable !== 1'b0) begin errors++; $display("FAIL reset_fsm_enable: got %b want 0", fsm_enable); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0)      begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (dbg_addr !== 6'h00)  begin errors++; $display("FAIL reset_dbg_addr: got %h want 00", dbg_addr); end
    checks++; if (dbg_wdata !== 32'h0) begin errors++; $display("FAIL reset_dbg_wdata: got %h want 0", dbg_wdata); end
  endtask

  task automatic test_basic();
    int t, dc;
    bit seen;
    logic [31:0] wd [3];
    wd[0] = 32'hA000_0001; wd[1] = 32'hA000_0002; wd[2] = 32'hA000_0003;
    for (int i = 0; i < 3; i++) push_word(wd[i]);
    wlog.delete();
    do_start(6'h10, 6'd3, t);
    @(negedge clk);
    checks++; if (dbg_reset !== 1'b1)  begin errors++; $display("FAIL basic_reset_t1: got %b want 1", dbg_reset); end
    checks++; if (busy !== 1'b1)       begin errors++; $display("FAIL basic_busy_t1: got %b want 1", busy); end
    wait_done(dc, seen);
    checks++; if (!seen || dc != t + 5 + 3*S) begin errors++; $display("FAIL basic_done_cyc: got %0d want %0d", dc - t, 5 + 3*S); end
    checks++; if (fsm_enable !== 1'b1 || dbg_reset !== 1'b0) begin
      errors++; $display("FAIL basic_run_outputs: got en=%b rst=%b want en=1 rst=0", fsm_enable, dbg_reset); end
    @(negedge clk);
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    checks++; if (wlog.size() != 3)    begin errors++; $display("FAIL basic_nwrites: got %0d want 3", wlog.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= wlog.size() || wlog[i].c != t + 5 + i*S || wlog[i].a !== 6'h10 + 6'(i) || wlog[i].d !== wd[i]) begin
        errors++;
        if (i < wlog.size())
          $display("FAIL basic_wr%0d: got cyc=+%0d addr=%h data=%h want cyc=+%0d addr=%h data=%h",
                   i, wlog[i].c - t, wlog[i].a, wlog[i].d, 5 + i*S, 6'h10 + 6'(i), wd[i]);
        else
          $display("FAIL basic_wr%0d: got none want addr=%h data=%h", i, 6'h10 + 6'(i), wd[i]);
      end
    end
  endtask

  task automatic test_wrap();
    int t, dc;
    bit seen;
    logic [5:0]  ea [4];
    logic [31:0] wd [4];
    ea[0] = 6'h3E; ea[1] = 6'h3F; ea[2] = 6'h00; ea[3] = 6'h01;
    for (int i = 0; i < 4; i++) begin
      wd[i] = 32'hB000_0000 + 32'(i);
      push_word(wd[i]);
    end
    wlog.delete();
    do_start(6'h3E, 6'd4, t);
    @(negedge clk);
    checks++; if (fsm_enable !== 1'b0) begin errors++; $display("FAIL wrap_enable_drop: got %b want 0", fsm_enable); end
    wait_done(dc, seen);
    checks++; if (!seen || dc != t + 5 + 4*S) begin errors++; $display("FAIL wrap_done_cyc: got %0d want %0d", dc - t, 5 + 4*S); end
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL wrap_nwrites: got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wlog.size() || wlog[i].a !== ea[i] || wlog[i].d !== wd[i]) begin
        errors++;
        if (i < wlog.size())
          $display("FAIL wrap_wr%0d: got addr=%h data=%h want addr=%h data=%h", i, wlog[i].a, wlog[i].d, ea[i], wd[i]);
        else
          $display("FAIL wrap_wr%0d: got none want addr=%h", i, ea[i]);
      end
    end
  endtask

  task automatic test_contention();
    int t, dc;
    bit seen;
    int          ec [4];
    logic [5:0]  ea [4];
    logic [31:0] wd [4];
    ec[0] = 5;     ea[0] = 6'h20; wd[0] = 32'hC000_0001;
    ec[1] = 5 + S; ea[1] = 6'h21; wd[1] = 32'hC000_0002;
    ec[2] = 5+2*S; ea[2] = 6'h05; wd[2] = 32'h5555_AAAA;
    ec[3] = 6+2*S; ea[3] = 6'h22; wd[3] = 32'hC000_0003;
    push_word(wd[0]); push_word(wd[1]); push_word(wd[3]);
    wlog.delete();
    do_start(6'h20, 6'd3, t);
    while (cyc < t + ec[2]) step();
    host_wr = 1'b1; host_addr = 6'h05; host_wdata = 32'h5555_AAAA;
    step();
    host_wr = 1'b0;
    wait_done(dc, seen);
    checks++; if (!seen || dc != t + 6 + 3*S) begin errors++; $display("FAIL cont_done_cyc: got %0d want %0d", dc - t, 6 + 3*S); end
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL cont_nwrites: got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wlog.size() || wlog[i].c != t + ec[i] || wlog[i].a !== ea[i] || wlog[i].d !== wd[i]) begin
        errors++;
        if (i < wlog.size())
          $display("FAIL cont_wr%0d: got cyc=+%0d addr=%h data=%h want cyc=+%0d addr=%h data=%h",
                   i, wlog[i].c - t, wlog[i].a, wlog[i].d, ec[i], ea[i], wd[i]);
        else
          $display("FAIL cont_wr%0d: got none want addr=%h", i, ea[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    int t, dc;
    bit seen;
    wlog.delete();
    do_start(6'h00, 6'd0, t);
    wait_done(dc, seen);
    checks++; if (!seen || dc != t + 5) begin errors++; $display("FAIL zero_done_cyc: got %0d want 5", dc - t); end
    checks++; if (wlog.size() != 0) begin errors++; $display("FAIL zero_nwrites: got %0d want 0", wlog.size()); end
  endtask

  task automatic test_starve_abort();
    int t;
    push_word(32'hE000_0001);
    push_word(32'hE000_0002);
    wlog.delete();
    do_start(6'h00, 6'd4, t);
    repeat (12) step();
    @(negedge clk);
    checks++; if (busy !== 1'b1 || dbg_reset !== 1'b1 || dbg_wr !== 1'b0) begin
      errors++; $display("FAIL starve_stall: got busy=%b rst=%b wr=%b want 1 1 0", busy, dbg_reset, dbg_wr); end
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL starve_nwrites: got %0d want 2", wlog.size()); end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || dbg_reset !== 1'b0 || wr_ready !== 1'b1 || fsm_enable !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b rst=%b rdy=%b en=%b want 0 0 1 0", busy, dbg_reset, wr_ready, fsm_enable); end
    // Queue words in IDLE, abort: a following load must find nothing.
    step();
    push_word(32'hF000_0001);
    push_word(32'hF000_0002);
    abort = 1'b1;
    step();
    abort = 1'b0;
    wlog.delete();
    do_start(6'h00, 6'd1, t);
    repeat (10) step();
    @(negedge clk);
    checks++; if (wlog.size() != 0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_flush: got writes=%0d busy=%b want 0 1", wlog.size(), busy); end
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
  endtask

  task automatic test_fifo_full();
    int t, dc;
    bit seen;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hD000_0001 + 32'(i);
      @(negedge clk);
      if (i == 3) begin
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready3: got %b want 1", wr_ready); end
      end
      if (i == 4) begin
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_ready4: got %b want 0", wr_ready); end
      end
      step();
    end
    wr_valid = 1'b0;
    wlog.delete();
    do_start(6'h08, 6'd4, t);
    wait_done(dc, seen);
    checks++; if (!seen) begin errors++; $display("FAIL full_done: got none want pulse"); end
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL full_nwrites: got %0d want 4", wlog.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wlog.size() || wlog[i].a !== 6'h08 + 6'(i) || wlog[i].d !== 32'hD000_0001 + 32'(i)) begin
        errors++;
        if (i < wlog.size())
          $display("FAIL full_wr%0d: got addr=%h data=%h want addr=%h data=%h",
                   i, wlog[i].a, wlog[i].d, 6'h08 + 6'(i), 32'hD000_0001 + 32'(i));
        else
          $display("FAIL full_wr%0d: got none", i);
      end
    end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after: got %b want 1", wr_ready); end
  endtask

`ifdef PRISM_LOADER_VERIFY_EN
  task automatic test_verify();
    int t, dc;
    bit seen;
    push_word(32'h9000_0001);
    push_word(32'h9000_0002);
    push_word(32'h9000_0003);
    corrupt = 1'b1;
    corrupt_addr = 6'h31;
    do_start(6'h30, 6'd3, t);
    while (cyc < t + 9) step();
    @(negedge clk);
    checks++; if (error !== 1'b1 || dbg_reset !== 1'b1 || fsm_enable !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL verify_fault: got err=%b rst=%b en=%b busy=%b want 1 1 0 0", error, dbg_reset, fsm_enable, busy); end
    step();
    corrupt = 1'b0;
    do_start(6'h32, 6'd1, t);
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL verify_clear: got %b want 0", error); end
    wait_done(dc, seen);
    checks++; if (!seen || dc != t + 7 || error !== 1'b0) begin
      errors++; $display("FAIL verify_rerun: got done_cyc=+%0d err=%b want +7 0", dc - t, error); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 64; i++) tbmem[i] = 32'h0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_addr = '0; word_count = '0;
    wr_valid = 1'b0; wr_data = '0;
    host_wr = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    step();
    test_basic();
    step();
    test_wrap();
    step();
    test_contention();
    step();
    test_zero_count();
    step();
    test_starve_abort();
    step();
    test_fifo_full();
`ifdef PRISM_LOADER_VERIFY_EN
    step();
    test_verify();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
